// File: rtl/pwm_from_count_if.sv
// ---------------------------------------------------------------------------
// pwm_from_count_if
// Purpose : valid/ready channel that carries new duty values from a control
//           source into pwm_from_count.
// Signals : duty_in    [WIDTH:0] high-time in counts (0..2^WIDTH, larger
//                                values are clamped by the consumer)
//           duty_valid           duty_in is offered by the source
//           duty_ready           consumer's pending slot is empty
// Modports: master = control source, slave = pwm_from_count
// ---------------------------------------------------------------------------
interface pwm_from_count_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH:0] duty_in;
  logic           duty_valid;
  logic           duty_ready;

  modport master (
    output duty_in,
    output duty_valid,
    input  duty_ready
  );

  modport slave (
    input  duty_in,
    input  duty_valid,
    output duty_ready
  );
endinterface

// File: rtl/pwm_from_count.sv
// ---------------------------------------------------------------------------
// pwm_from_count
// Purpose : turns the value of a free-running WIDTH-bit counter into a
//           registered PWM waveform. The duty cycle is double-buffered and
//           only changes at a counter wrap; enabling waits for a wrap so the
//           first emitted period is always complete.
// Ports   : clk           rising-edge clock
//           rst           synchronous active-high reset
//           count_in      counter value from the upstream counter
//           enable        run request
//           duty_if       slave side of the duty valid/ready channel
//           pwm_out       registered PWM output
//           period_start  one-cycle pulse after each wrap while synced/running
//           periods_done  saturating completed-period count (only when the
//                         macro PWM_PERIOD_CNT_EN is defined)
// Build   : define PWM_PERIOD_CNT_EN to add the periods_done port/counter.
// ---------------------------------------------------------------------------
module pwm_from_count #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             enable,
  pwm_from_count_if.slave  duty_if,
  output logic             pwm_out,
  output logic             period_start
`ifdef PWM_PERIOD_CNT_EN
  ,
  output logic [15:0]      periods_done
`endif
);

  localparam logic [WIDTH:0] DUTY_MAX = {1'b1, {WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state_q;
  logic             pwm_q;
  logic             period_start_q;

  logic [WIDTH-1:0] prev_count_q;
  logic [WIDTH:0]   pending_q;
  logic             pending_valid_q;
  logic             pending_valid_d;
  logic [WIDTH:0]   active_duty_q;
  logic             duty_ready_q;

  logic             wrap;
  logic             accept;
  logic             apply;
  logic [WIDTH:0]   duty_clamped;
  logic [WIDTH:0]   duty_eff;
  logic             pwm_cmp;

  // A drop in the counter value marks a period boundary. This also catches
  // an upstream counter reset in mid-count; a stalled counter is not a wrap.
  always_comb begin
    wrap         = (count_in < prev_count_q);
    accept       = duty_if.duty_valid && duty_ready_q;
    apply        = wrap && pending_valid_q;
    duty_clamped = (duty_if.duty_in > DUTY_MAX) ? DUTY_MAX : duty_if.duty_in;
    // On the wrap cycle the pending value is used directly so the very first
    // sample of the new period already reflects the new duty.
    duty_eff     = apply ? pending_q : active_duty_q;
    pwm_cmp      = ({1'b0, count_in} < duty_eff);
  end

  // accept and apply are mutually exclusive: accept needs an empty slot,
  // apply needs a full one. An accept on a wrap cycle therefore only fills
  // the slot and waits for the following wrap.
  always_comb begin
    pending_valid_d = pending_valid_q;
    if (accept) begin
      pending_valid_d = 1'b1;
    end else if (apply) begin
      pending_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_count_q    <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      active_duty_q   <= '0;
      duty_ready_q    <= 1'b1;
    end else begin
      prev_count_q    <= count_in;
      pending_valid_q <= pending_valid_d;
      duty_ready_q    <= !pending_valid_d;
      if (accept) begin
        pending_q <= duty_clamped;
      end
      if (apply) begin
        active_duty_q <= pending_q;
      end
    end
  end

  // Run-control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      period_start_q <= wrap && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          pwm_q <= 1'b0;
          if (enable) begin
            state_q <= SYNC;
          end
        end
        SYNC: begin
          if (!enable) begin
            state_q <= IDLE;
            pwm_q   <= 1'b0;
          end else if (wrap) begin
            // The wrap sample is the first count of a full period, so it is
            // already driven from the compare.
            state_q <= RUN;
            pwm_q   <= pwm_cmp;
          end else begin
            pwm_q <= 1'b0;
          end
        end
        RUN: begin
          if (!enable) begin
            state_q <= IDLE;
            pwm_q   <= 1'b0;
          end else begin
            pwm_q <= pwm_cmp;
          end
        end
        default: begin
          state_q <= IDLE;
          pwm_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PWM_PERIOD_CNT_EN
  logic [15:0] periods_done_q;

  // A wrap seen in RUN closes a full period; the SYNC->RUN wrap only opens one.
  always_ff @(posedge clk) begin
    if (rst) begin
      periods_done_q <= '0;
    end else if (wrap && (state_q == RUN) && (periods_done_q != 16'hFFFF)) begin
      periods_done_q <= periods_done_q + 16'd1;
    end
  end

  assign periods_done = periods_done_q;
`endif

  assign pwm_out            = pwm_q;
  assign period_start       = period_start_q;
  assign duty_if.duty_ready = duty_ready_q;

endmodule

// File: tb/tb_pwm_from_count.sv
// ---------------------------------------------------------------------------
// tb_pwm_from_count
// Directed bench for pwm_from_count (WIDTH = 8). Duty values accepted over the
// handshake are pushed to a scoreboard queue; each period start pops the next
// value (if any), and the high-time measured over that period is compared
// against it. Builds with or without PWM_PERIOD_CNT_EN.
// ---------------------------------------------------------------------------
module tb_pwm_from_count;

  logic       clk;
  logic       rst;
  logic [7:0] count_in;
  logic       enable;
  logic       pwm_out;
  logic       period_start;
`ifdef PWM_PERIOD_CNT_EN
  logic [15:0] periods_done;
`endif

  pwm_from_count_if #(.WIDTH(8)) duty_if ();

  pwm_from_count #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .count_in     (count_in),
    .enable       (enable),
    .duty_if      (duty_if),
    .pwm_out      (pwm_out),
    .period_start (period_start)
`ifdef PWM_PERIOD_CNT_EN
    ,
    .periods_done (periods_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] cnt;
  int         sb_q[$];
  int         cur_duty;
  int         run_wraps;
  bit         in_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int d);
    return (d > 256) ? 256 : d;
  endfunction

  // One clock: drive the counter value, sample outputs 1 time unit after the edge.
  task automatic step();
    count_in = cnt;
    @(posedge clk);
    #1;
    cnt = cnt + 8'd1;
  endtask

  // Cycles where the output must stay quiet (IDLE or SYNC before a wrap).
  task automatic idle_run(input int n, input string tag);
    int highs;
    int starts;
    highs  = 0;
    starts = 0;
    for (int i = 0; i < n; i++) begin
      step();
      highs  += int'(pwm_out);
      starts += int'(period_start);
    end
    check({tag, "_highs"}, highs, 0);
    check({tag, "_starts"}, starts, 0);
  endtask

  // One period beginning at count 0 (the wrap), len counts long. Optionally
  // offers a duty value at index acc_at.
  task automatic run_period(input int len, input int acc_at, input int acc_val);
    int highs;
    int starts;
    int rdy_low;
    bit applied;
    highs   = 0;
    starts  = 0;
    rdy_low = 0;
    applied = 1'b0;
    cnt     = 8'd0;
    if (sb_q.size() > 0) begin
      cur_duty = sb_q.pop_front();
      applied  = 1'b1;
    end
    for (int i = 0; i < len; i++) begin
      if (i == acc_at) begin
        check("ready_before_accept", duty_if.duty_ready, 1);
        duty_if.duty_valid = 1'b1;
        duty_if.duty_in    = 9'(acc_val);
      end
      step();
      if (i == acc_at) begin
        duty_if.duty_valid = 1'b0;
        sb_q.push_back(clamp(acc_val));
      end
      if (i == 0) begin
        check("period_start_pulse", period_start, 1);
        if (applied) check("ready_after_wrap", duty_if.duty_ready, 1);
      end
      highs  += int'(pwm_out);
      starts += int'(period_start);
      if (acc_at >= 0 && i >= acc_at && !duty_if.duty_ready) rdy_low++;
    end
    $display("period len=%0d duty=%0d highs=%0d starts=%0d", len, cur_duty, highs, starts);
    check("high_count", highs, (cur_duty < len) ? cur_duty : len);
    check("start_count", starts, 1);
    if (acc_at >= 0) check("ready_low_span", rdy_low, len - acc_at);
    if (in_run) run_wraps++;
    in_run = 1'b1;
  endtask

  initial begin
    rst                = 1'b1;
    enable             = 1'b0;
    count_in           = 8'd0;
    duty_if.duty_in    = '0;
    duty_if.duty_valid = 1'b0;
    cnt                = 8'd0;
    cur_duty           = 0;
    run_wraps          = 0;
    in_run             = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_pwm_out", pwm_out, 0);
    check("rst_period_start", period_start, 0);
    check("rst_duty_ready", duty_if.duty_ready, 1);
`ifdef PWM_PERIOD_CNT_EN
    check("rst_periods_done", periods_done, 0);
`endif

    // Duty 64 accepted while idle; becomes active at the first wrap.
    duty_if.duty_valid = 1'b1;
    duty_if.duty_in    = 9'd64;
    step();
    duty_if.duty_valid = 1'b0;
    sb_q.push_back(64);
    $display("accept duty 64 in IDLE");
    check("ready_after_accept", duty_if.duty_ready, 0);
    idle_run(15, "idle");

    // Enable at count 0x10: nothing until after 0xFF->0x00.
    enable = 1'b1;
    in_run = 1'b0;
    idle_run(240, "sync");

    run_period(256, -1, 0);      // SYNC->RUN wrap, 64 high
    run_period(256, -1, 0);      // 64
    run_period(256, 8'h80, 200); // mid-period update, still 64
    run_period(256, -1, 0);      // 200
`ifdef PWM_PERIOD_CNT_EN
    check("periods_done_3", periods_done, 3);
`endif
    run_period(256, 0, 10);      // accept on the wrap cycle: still 200
    run_period(256, -1, 0);      // 10
    run_period(256, 8'h40, 0);   // 10
    run_period(256, 8'h40, 256); // 0
    run_period(256, 8'h40, 300); // 256
    run_period(256, -1, 0);      // 256 (clamped 300)

    // Upstream counter reset 0x73->0x00 with a pending duty of 30.
    run_period(8'h74, 8'h20, 30);
    run_period(256, -1, 0);      // wrap on the jump, 30 applied

    // Enable drop mid-period: output low on the next cycle.
    cnt = 8'd0;
    step();
    check("drop_period_start", period_start, 1);
    run_wraps++;
    repeat (4) step();
    check("pwm_before_drop", pwm_out, 1);
    enable = 1'b0;
    step();
    $display("enable dropped at count %0d", cnt - 8'd1);
    check("pwm_after_drop", pwm_out, 0);
    idle_run(250, "post_drop");
    idle_run(5, "idle_wrap");
`ifdef PWM_PERIOD_CNT_EN
    check("periods_done_total", periods_done, run_wraps);
`endif

    // Reset with a pending duty: pending and active duty are both discarded.
    duty_if.duty_valid = 1'b1;
    duty_if.duty_in    = 9'd100;
    step();
    duty_if.duty_valid = 1'b0;
    check("ready_pending_100", duty_if.duty_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_q.delete();
    cur_duty  = 0;
    run_wraps = 0;
    $display("mid-period reset applied");
    check("ready_after_rst", duty_if.duty_ready, 1);
`ifdef PWM_PERIOD_CNT_EN
    check("periods_done_after_rst", periods_done, 0);
`endif
    enable = 1'b1;
    in_run = 1'b0;
    idle_run(256 - int'(cnt), "resync");
    run_period(256, -1, 0);      // 0 highs: nothing survived reset
    run_period(256, -1, 0);
`ifdef PWM_PERIOD_CNT_EN
    check("periods_done_final", periods_done, run_wraps);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_from_count.md
# pwm_from_count

Downstream consumer of the free-running 8-bit counter. It samples the counter value each clock and produces a registered PWM waveform whose duty cycle is double-buffered, so updates take effect only at a counter wrap. Duty values arrive over a valid/ready handshake from a control source. Enable changes are synchronised to period boundaries, so the output never emits a partial first period.

## Interface
- `WIDTH`, default 8: counter width; the period is 2^WIDTH counts.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `count_in`  in  WIDTH  counter value from the upstream counter.
- `enable`  in  1  run request.
- `duty_in`  in  WIDTH+1  high-time in counts, 0..2^WIDTH; values above 2^WIDTH are clamped to 2^WIDTH.
- `duty_valid`  in  1  `duty_in` is offered.
- `duty_ready`  out  1  the pending slot is empty.
- `pwm_out`  out  1  PWM output, registered.
- `period_start`  out  1  one-cycle pulse at each period start while running.
- `periods_done`  out  16  completed-period count; present only with `PWM_PERIOD_CNT_EN`.

## Operation
- **Wrap detection:**
  - `prev_count` registers `count_in` every cycle.
  - `wrap = (count_in < prev_count)`.
  - This also fires when the upstream counter is reset mid-count, for example 0x73→0x00.
- **Duty buffering:**
  - Accept when `duty_valid && duty_ready`. The clamped value is stored into `pending`, and `pending_valid` is set.
  - `duty_ready = !pending_valid`, registered.
  - On `wrap` with `pending_valid` set: `active_duty <= pending` and `pending_valid` clears.
  - An accept in the same cycle as `wrap` loads `pending` only. It is applied at the next wrap.
- **FSM:**
  - IDLE: `pwm_out` is 0. When `enable` = 1, go to SYNC.
  - SYNC: `pwm_out` is 0. On `wrap`, go to RUN. When `enable` = 0, go to IDLE.
  - RUN: `pwm_out <= (count_in < duty_eff)`. When `enable` = 0, go to IDLE, and `pwm_out` is 0 from the next cycle.
  - `duty_eff` is `pending` when `wrap && pending_valid` this cycle; otherwise it is `active_duty`. This makes the first sample of a new period use the new duty.
- **Arithmetic:**
  - The compare is (WIDTH+1)-bit, with `count_in` zero-extended.
  - Duty 0 gives a constant low.
  - Duty 2^WIDTH gives a constant high.
  - Duty d gives d high counts out of 2^WIDTH.
- **`period_start`:** pulses for one cycle, one cycle after any `wrap` seen in SYNC or RUN. This includes the SYNC→RUN transition.
- **Reset values:**
  - `pwm_out` = 0, `period_start` = 0, `duty_ready` = 1.
  - `active_duty` = 0, `pending_valid` = 0, `prev_count` = 0.
  - State = IDLE.
  - `periods_done` = 0.
- Asserting `rst` mid-period discards both `pending` and `active_duty`.

## Timing
- `count_in` to `pwm_out` latency is 1 clock.
- Duty accepted at cycle t is applied at the first `wrap` strictly after t.
- Worst-case latency from `enable` rising to the first high `pwm_out` is 2^WIDTH + 1 cycles.
- `enable` falling: `pwm_out` is 0 one cycle later. There is no wait for a wrap.
- `duty_ready` drops the cycle after an accept. It rises the cycle after the wrap that consumes `pending`.
- `count_in` holding steady is not a wrap. The block tolerates a stalled counter and holds its output.

## Configuration
- **`PWM_PERIOD_CNT_EN` defined:**
  - `periods_done` port exists.
  - It increments on each `wrap` in RUN and saturates at 0xFFFF.
  - It clears on `rst` only. Disabling does not clear it.
- **Undefined:** the port and its counter are absent. All other behaviour is identical.

## Test plan
- **Basic duty:** reset, then counter running 0..255; accept duty 64, enable 1 → after the next wrap, `pwm_out` high for exactly 64 cycles per 256, and `period_start` pulses every 256 cycles.
- **Duty update mid-period:** running at 64, accept 200 at count 0x80 → current period keeps 64 high counts; the next period has 200. `duty_ready` is 0 from count 0x81 until one cycle after the wrap.
- **Extremes:**
  - Duty 0 → `pwm_out` constant 0.
  - Duty 256 → constant 1 across wrap.
  - Duty 300 → clamped to 256, constant 1.
- **Simultaneous events:** accept duty 10 in the wrap cycle while `pending_valid` = 0 → that period uses the old duty; the following period has 10 high counts.
- **Upstream reset:** the counter jumps 0x73→0x00 while running → wrap detected, `period_start` pulses, pending duty applied.
- **Enable control and `periods_done`:**
  - Enable at count 0x10 → `pwm_out` stays 0 until after 0xFF→0x00.
  - Drop enable → `pwm_out` is 0 next cycle.
  - With `PWM_PERIOD_CNT_EN`, `periods_done` = 3 after three RUN wraps.
